// File: rtl/cmd_addr_sequencer_if.sv
// Request and latch-unit signal bundle for cmd_addr_sequencer.
// Handshakes: start is taken only while busy=0 (done cycle included); lu_activate is a
// one-cycle request, lu_busy high acknowledges it and its fall completes the op.
interface cmd_addr_sequencer_if;
  logic        start;
  logic [7:0]  cmd1;
  logic [2:0]  addr_count;
  logic [39:0] addr;
  logic        has_cmd2;
  logic [7:0]  cmd2;
  logic        wait_rb;
  logic        nand_rb;
  logic        lu_busy;
  logic        lu_activate;
  logic        lu_latch_type;
  logic [15:0] lu_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, cmd1, addr_count, addr, has_cmd2, cmd2, wait_rb, nand_rb, lu_busy,
    input  lu_activate, lu_latch_type, lu_data, busy, done, error
  );

  modport slave (
    input  start, cmd1, addr_count, addr, has_cmd2, cmd2, wait_rb, nand_rb, lu_busy,
    output lu_activate, lu_latch_type, lu_data, busy, done, error
  );
endinterface

// File: rtl/cmd_addr_sequencer.sv
// Expands one command/address request into single latch-unit operations, then
// optionally times t_wb and waits on ready/busy with a timeout.
module cmd_addr_sequencer #(
  parameter int T_WB       = 20,
  parameter int RB_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 nreset,
  cmd_addr_sequencer_if.slave  bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD1    = 3'd1,
    S_ADDR    = 3'd2,
    S_CMD2    = 3'd3,
    S_TWB     = 3'd4,
    S_WAIT_RB = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE = 2'd0,
    P_ACK   = 2'd1,
    P_DRAIN = 2'd2
  } phase_t;

  localparam logic [15:0] TWB_LOAD = 16'(T_WB);
  localparam logic [15:0] RB_LIMIT = 16'(RB_TIMEOUT);

  state_t      state;
  phase_t      phase;
  logic [39:0] r_addr;
  logic [2:0]  r_count;
  logic [2:0]  r_idx;
  logic        r_has_cmd2;
  logic [7:0]  r_cmd2;
  logic        r_wait_rb;
  logic [15:0] twb_cnt;
  logic [15:0] rb_cnt;

  logic        act_q;
  logic        type_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // What follows the op currently draining: another address byte, cmd2, or the tail.
  logic        go_addr;
  logic        go_cmd2;
  logic [2:0]  nxt_idx;
  logic [39:0] addr_shift;
  logic [7:0]  nxt_byte;
  state_t      nxt_state;

  always_comb begin
    go_addr    = 1'b0;
    go_cmd2    = 1'b0;
    nxt_idx    = r_idx;
    addr_shift = 40'd0;
    nxt_byte   = 8'h00;
    nxt_state  = S_DONE;
    if (state == S_CMD1) begin
      nxt_idx = 3'd0;
      go_addr = (r_count != 3'd0);
    end else if (state == S_ADDR) begin
      nxt_idx = r_idx + 3'd1;
      go_addr = ((r_idx + 3'd1) < r_count);
    end
    go_cmd2    = !go_addr && r_has_cmd2 && (state == S_CMD1 || state == S_ADDR);
    addr_shift = r_addr >> {nxt_idx, 3'b000};
    nxt_byte   = go_addr ? addr_shift[7:0] : r_cmd2;
    if (go_addr)        nxt_state = S_ADDR;
    else if (go_cmd2)   nxt_state = S_CMD2;
    else if (r_wait_rb) nxt_state = S_TWB;
    else                nxt_state = S_DONE;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      phase      <= P_ISSUE;
      r_addr     <= 40'd0;
      r_count    <= 3'd0;
      r_idx      <= 3'd0;
      r_has_cmd2 <= 1'b0;
      r_cmd2     <= 8'h00;
      r_wait_rb  <= 1'b0;
      twb_cnt    <= 16'd0;
      rb_cnt     <= 16'd0;
      act_q      <= 1'b0;
      type_q     <= 1'b0;
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      act_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_addr     <= bus.addr;
            r_count    <= (bus.addr_count > 3'd5) ? 3'd5 : bus.addr_count;
            r_idx      <= 3'd0;
            r_has_cmd2 <= bus.has_cmd2;
            r_cmd2     <= bus.cmd2;
            r_wait_rb  <= bus.wait_rb;
            state      <= S_CMD1;
            phase      <= P_ISSUE;
            act_q      <= 1'b1;
            type_q     <= 1'b0;
            data_q     <= {8'h00, bus.cmd1};
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CMD1, S_ADDR, S_CMD2: begin
          case (phase)
            P_ISSUE: phase <= P_ACK;
            P_ACK:   if (bus.lu_busy) phase <= P_DRAIN;
            default: begin
              // Byte and type stay put until this point, so they never move under lu_busy.
              if (!bus.lu_busy) begin
                state <= nxt_state;
                r_idx <= nxt_idx;
                phase <= P_ISSUE;
                if (go_addr || go_cmd2) begin
                  act_q  <= 1'b1;
                  type_q <= go_addr;
                  data_q <= {8'h00, nxt_byte};
                end else if (r_wait_rb) begin
                  twb_cnt <= TWB_LOAD;
                end else begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                end
              end
            end
          endcase
        end
        S_TWB: begin
          if (twb_cnt <= 16'd1) begin
            state  <= S_WAIT_RB;
            rb_cnt <= 16'd0;
          end else begin
            twb_cnt <= twb_cnt - 16'd1;
          end
        end
        S_WAIT_RB: begin
          if (bus.nand_rb) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
          end else if ((rb_cnt + 16'd1) == RB_LIMIT) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            rb_cnt <= rb_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.lu_activate   = act_q;
  assign bus.lu_latch_type = type_q;
  assign bus.lu_data       = data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = err_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_cmd_addr_sequencer.sv
// Bench for cmd_addr_sequencer: latch-unit model, op scoreboard and per-scenario tasks.
module tb_cmd_addr_sequencer;
  localparam int T_WB   = 20;
  localparam int RB_TO  = 100;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [2:0] dbg_state;

  cmd_addr_sequencer_if bus();

  cmd_addr_sequencer #(.T_WB(T_WB), .RB_TIMEOUT(RB_TO)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [16:0] exp_q[$];
  int act_cnt = 0;
  int done_cnt = 0;
  int ops_done = 0;
  int fall_ref = 0;
  logic twb_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Latch-unit model plus op scoreboard, evaluated on every falling edge.
  initial begin
    int busy_left;
    logic arm;
    logic [16:0] held;
    logic [16:0] e;
    busy_left = 0;
    arm = 1'b0;
    held = '0;
    bus.lu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        bus.lu_busy = 1'b0;
        busy_left = 0;
        arm = 1'b0;
        exp_q.delete();
      end else begin
        if (dbg_state == 3'd4) twb_seen = 1'b1;
        if (bus.lu_busy) begin
          checks++;
          if ({bus.lu_latch_type, bus.lu_data} !== held) begin
            errors++;
            $display("FAIL hold_stable: got %h required %h", {bus.lu_latch_type, bus.lu_data}, held);
          end
        end
        if (bus.lu_activate) begin
          act_cnt++;
          held = {bus.lu_latch_type, bus.lu_data};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_op: got %h required none", held);
          end else begin
            e = exp_q.pop_front();
            if (held !== e) begin
              errors++;
              $display("FAIL op_data: got %h required %h", held, e);
            end
          end
        end
        if (bus.done) done_cnt++;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            bus.lu_busy = 1'b0;
            fall_ref = cyc + 1;
            ops_done++;
          end
        end else if (arm) begin
          arm = 1'b0;
          bus.lu_busy = 1'b1;
          busy_left = $urandom_range(1, 4);
        end
        if (bus.lu_activate) arm = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [7:0] c1, input logic [2:0] cnt, input logic [39:0] a,
                           input logic h2, input logic [7:0] c2, input logic wrb);
    int n;
    logic [39:0] sh;
    n = (cnt > 3'd5) ? 5 : int'(cnt);
    exp_q.push_back({1'b0, 8'h00, c1});
    for (int i = 0; i < n; i++) begin
      sh = a >> (8 * i);
      exp_q.push_back({1'b1, 8'h00, sh[7:0]});
    end
    if (h2) exp_q.push_back({1'b0, 8'h00, c2});
    bus.cmd1 = c1; bus.addr_count = cnt; bus.addr = a;
    bus.has_cmd2 = h2; bus.cmd2 = c2; bus.wait_rb = wrb;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.lu_activate} !== 2'b11) begin
      errors++;
      $display("FAIL first_issue: got busy/act %b required 11", {bus.busy, bus.lu_activate});
    end
  endtask

  task automatic wait_ops(input int target);
    for (int i = 0; i < 400 && ops_done < target; i++) tick();
    checks++;
    if (ops_done < target) begin
      errors++;
      $display("FAIL ops_timeout: got %0d required %0d", ops_done, target);
    end
  endtask

  task automatic wait_done(input int limit, output int dcyc, output logic derr);
    dcyc = -1;
    derr = 1'bx;
    for (int i = 0; i < limit; i++) begin
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        derr = bus.error;
        break;
      end
      tick();
    end
    checks++;
    if (dcyc < 0) begin
      errors++;
      $display("FAIL done_timeout: got none required done within %0d", limit);
    end else if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cmd1 = 8'h00; bus.addr_count = 3'd0; bus.addr = 40'd0;
    bus.has_cmd2 = 1'b0; bus.cmd2 = 8'h00; bus.wait_rb = 1'b0; bus.nand_rb = 1'b1;
    nreset = 1'b0;
    repeat (3) tick();
    check_int("reset_outputs", int'({bus.lu_activate, bus.lu_latch_type, bus.lu_data,
                                     bus.busy, bus.done, bus.error}), 0);
    check_int("reset_state", int'(dbg_state), 0);
    nreset = 1'b1;
    repeat (2) tick();
    check_int("idle_after_release", int'({bus.busy, bus.lu_activate, bus.done}), 0);
  endtask

  task automatic test_read_page();
    int ops0, a0, rf, dcyc;
    logic derr;
    ops0 = ops_done; a0 = act_cnt;
    bus.nand_rb = 1'b0;
    drive_req(8'h00, 3'd5, 40'h0504030201, 1'b1, 8'h30, 1'b1);
    wait_ops(ops0 + 7);
    rf = fall_ref;
    for (int i = 0; i < 200 && cyc < rf + T_WB + 39; i++) begin
      tick();
      if (cyc == rf) check_int("page_twb_entry", int'(dbg_state), 4);
      if (cyc == rf + T_WB - 1) check_int("page_twb_last", int'(dbg_state), 4);
      if (cyc == rf + T_WB) check_int("page_waitrb_entry", int'(dbg_state), 5);
    end
    bus.nand_rb = 1'b1;
    wait_done(100, dcyc, derr);
    check_int("page_done_cycle", dcyc - rf, T_WB + 40);
    check_int("page_error", int'(derr), 0);
    check_int("page_op_count", act_cnt - a0, 7);
    check_int("page_queue_left", exp_q.size(), 0);
    tick();
    bus.nand_rb = 1'b0;
  endtask

  task automatic test_reset_cmd();
    int ops0, a0, dcyc;
    logic derr;
    ops0 = ops_done; a0 = act_cnt;
    bus.nand_rb = 1'b1;
    drive_req(8'hFF, 3'd0, 40'd0, 1'b0, 8'h00, 1'b1);
    wait_ops(ops0 + 1);
    wait_done(100, dcyc, derr);
    check_int("rst_done_cycle", dcyc - fall_ref, T_WB + 1);
    check_int("rst_error", int'(derr), 0);
    check_int("rst_op_count", act_cnt - a0, 1);
    tick();
  endtask

  task automatic test_read_id();
    int ops0, a0, dcyc;
    logic derr;
    ops0 = ops_done; a0 = act_cnt;
    twb_seen = 1'b0;
    drive_req(8'h90, 3'd1, 40'd0, 1'b0, 8'h00, 1'b0);
    wait_ops(ops0 + 2);
    wait_done(20, dcyc, derr);
    check_int("id_done_cycle", dcyc, fall_ref);
    check_int("id_op_count", act_cnt - a0, 2);
    check_int("id_no_twb", int'(twb_seen), 0);
    tick();
  endtask

  task automatic test_timeout();
    int ops0, dcyc;
    logic derr;
    ops0 = ops_done;
    bus.nand_rb = 1'b0;
    drive_req(8'h70, 3'd0, 40'd0, 1'b0, 8'h00, 1'b1);
    wait_ops(ops0 + 1);
    wait_done(T_WB + RB_TO + 20, dcyc, derr);
    check_int("to_done_cycle", dcyc - fall_ref, T_WB + RB_TO);
    check_int("to_error", int'(derr), 1);
    tick();
  endtask

  task automatic test_robustness();
    int a0, dcyc;
    logic derr;
    a0 = act_cnt;
    bus.nand_rb = 1'b1;
    drive_req(8'h00, 3'd7, 40'hA5B4C3D2E1, 1'b1, 8'h30, 1'b1);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        derr = bus.error;
        break;
      end
      bus.cmd1 = 8'($urandom); bus.addr = {8'($urandom), 32'($urandom)};
      bus.addr_count = 3'($urandom_range(0, 7)); bus.has_cmd2 = 1'($urandom);
      bus.cmd2 = 8'($urandom); bus.wait_rb = 1'($urandom);
      bus.start = (bus.busy === 1'b1) ? 1'($urandom) : 1'b0;
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (dcyc < 0) begin
      errors++;
      $display("FAIL robust_done: got none required done");
    end
    check_int("robust_error", int'(derr), 0);
    check_int("robust_op_count", act_cnt - a0, 7);
    repeat (8) tick();
    check_int("robust_no_requeue", act_cnt - a0, 7);
    check_int("robust_idle", int'(bus.busy), 0);
  endtask

  task automatic test_back_to_back();
    int a0, dcyc;
    logic derr;
    a0 = act_cnt;
    drive_req(8'h90, 3'd1, 40'h20, 1'b0, 8'h00, 1'b0);
    wait_done(100, dcyc, derr);
    drive_req(8'h60, 3'd3, 40'h0C0B0A, 1'b1, 8'hD0, 1'b0);
    wait_done(200, dcyc, derr);
    check_int("b2b_op_count", act_cnt - a0, 7);
    check_int("b2b_queue_left", exp_q.size(), 0);
    tick();
  endtask

  task automatic test_reset_mid_op();
    int a0, d0;
    a0 = act_cnt;
    bus.nand_rb = 1'b0;
    drive_req(8'h00, 3'd5, 40'h0504030201, 1'b1, 8'h30, 1'b1);
    for (int i = 0; i < 100 && act_cnt < a0 + 3; i++) tick();
    check_int("mid_third_op", act_cnt - a0, 3);
    check_int("mid_act_before", int'(bus.lu_activate), 1);
    d0 = done_cnt;
    nreset = 1'b0;
    #1;
    check_int("mid_outputs_zero", int'({bus.lu_activate, bus.lu_latch_type, bus.lu_data,
                                        bus.busy, bus.done, bus.error}), 0);
    repeat (3) tick();
    nreset = 1'b1;
    repeat (4) tick();
    check_int("mid_no_done", done_cnt - d0, 0);
    check_int("mid_idle", int'(bus.busy), 0);
    test_read_id();
  endtask

  initial begin
    test_reset();
    test_read_page();
    test_reset_cmd();
    test_read_id();
    test_timeout();
    test_robustness();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
